pc_call_unit: RTL
=================

Name: pc_call_unit

Overview:
- Parametrised successor of the multi-cycle TOY datapath's PC register.
- Holds the program counter and supports hold, increment, jump, call and return.
- Calls and returns use an internal LIFO return-address stack with full/empty flags and sticky error flags.
- Sits between the control FSM, which drives op/en, and the instruction-memory address path.

Parameters:
- PC_W, 12, program counter width in bits.
- STEP, 1, increment added by INC and used to form the CALL return address.
- STACK_DEPTH, 4, number of return-address entries (≥2).
- RESET_PC, 0, value loaded into the PC on reset.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- en  input  1  operation strobe; 0 holds all state regardless of op.
- op  input  3  0=HOLD, 1=INC, 2=JUMP, 3=CALL, 4=RET, 5..7 behave as HOLD.
- pc_target  input  PC_W  destination for JUMP/CALL.
- err_clr  input  1  clears the sticky error flags.
- pc_out  output  PC_W  current PC, registered.
- depth  output  clog2(STACK_DEPTH+1)  number of valid stack entries.
- stack_full  output  1  depth==STACK_DEPTH.
- stack_empty  output  1  depth==0.
- ovf_err  output  1  sticky; set when a CALL is attempted while full.
- unf_err  output  1  sticky; set when a RET is attempted while empty.

Behaviour:
- Reset (reset==0 at an edge): pc_out=RESET_PC, depth=0, stack_empty=1, stack_full=0, ovf_err=0, unf_err=0. Stack contents are don't-care.
- Reset has priority over en, op and err_clr, and aborts any in-flight op.
- Every op completes in one cycle. The new pc_out and depth are visible on the edge after the op is sampled.
- en==0 or op HOLD/undefined: no state change.
- INC: pc_out <= pc_out+STEP, modulo 2^PC_W; wrap-around is silent.
- JUMP: pc_out <= pc_target. The stack is untouched.
- CALL, not full: push (pc_out+STEP) mod 2^PC_W, depth+1, pc_out <= pc_target.
- CALL, full: no push and pc_out unchanged; ovf_err <= 1.
- RET, not empty: pc_out <= top entry, depth-1.
- RET, empty: pc_out unchanged; unf_err <= 1.
- err_clr==1 clears both error flags on that edge.
- If an error-setting event coincides with err_clr, the set wins and the flag ends at 1.
- stack_full and stack_empty are decoded combinationally from the registered depth.
- The stack is implemented as an array plus pointer, with no shifting. Only the accessed entry is written.

Optional Feature:
- Macro PC_CALL_UNIT_PREV_PC_EN.
- Defined: adds output pc_prev (PC_W). pc_prev <= old pc_out on every edge where pc_out changes value; it is unchanged otherwise. Reset value is RESET_PC.
- Not defined: the port and register are absent, and all other behaviour is identical.

Decomposition:
- Package pc_call_unit_pkg holds:
  - op encoding constants OP_HOLD, OP_INC, OP_JUMP, OP_CALL, OP_RET;
  - the op width constant (3);
  - a clog2 helper function.
- One sub-module, ret_stack: a parametrised LIFO with push, pop, data_in, top, depth, full and empty.
  - It has no error logic; the errors are owned by pc_call_unit.

Test Plan:
- Reset with reset=0 for 2 cycles, RESET_PC=0x010 -> pc_out=0x010, depth=0, empty=1, errors 0. Holding reset low while en=1/op=INC also keeps pc_out=0x010.
- INC wrap: JUMP 0xFFE, then INC twice (STEP=1) -> pc_out 0xFFF, then 0x000, with no error flags.
- Nested calls: from pc=0x100, CALL 0x200, then CALL 0x300. Then RET, RET -> pc_out 0x200, 0x300, 0x201, 0x101; depth 1,2,1,0.
- Overflow: 4 CALLs to fill the stack, then a 5th CALL 0x555 -> pc_out unchanged, depth=4, full=1, ovf_err=1. Four RETs then return addresses in correct LIFO order.
- Underflow and clear:
  - RET on empty -> pc_out unchanged, unf_err=1.
  - err_clr alone -> unf_err=0.
  - RET on empty with err_clr=1 in the same cycle -> unf_err=1.
- en gating and optional feature:
  - en=0 with op=CALL -> no change to pc_out or depth.
  - With PC_CALL_UNIT_PREV_PC_EN: JUMP 0x0A0 from 0x050 -> pc_prev=0x050. A following HOLD leaves pc_prev=0x050.

Source files
------------

// File: rtl/pc_call_unit_pkg.sv
// pc_call_unit_pkg: op encoding, op width and a constant clog2 helper shared by the PC/call unit.
package pc_call_unit_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_HOLD = 3'd0;
    localparam logic [OP_W-1:0] OP_INC  = 3'd1;
    localparam logic [OP_W-1:0] OP_JUMP = 3'd2;
    localparam logic [OP_W-1:0] OP_CALL = 3'd3;
    localparam logic [OP_W-1:0] OP_RET  = 3'd4;

    // Ceiling log2; clog2(1) == 0, usable in constant expressions.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/pc_call_unit_ret_stack.sv
// ret_stack: parametrised LIFO (array plus pointer, no shifting).
// Ports: clk, reset (sync active-low), push/pop strobes, data_in, top (current top entry),
// depth (valid entries), full, empty. Push while full and pop while empty are ignored.
module ret_stack
    import pc_call_unit_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 4,
    localparam int DW    = clog2(DEPTH + 1),
    localparam int AW    = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] top,
    output logic [DW-1:0]     depth,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     rd_idx;
    logic              do_push;
    logic              do_pop;

    assign full    = depth == DW'(DEPTH);
    assign empty   = depth == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // depth doubles as the write pointer; the top entry sits one below it.
    assign wr_idx  = AW'(depth);
    assign rd_idx  = AW'(depth - 1'b1);
    assign top     = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (!reset)
            depth <= '0;
        else if (do_push)
            depth <= depth + 1'b1;
        else if (do_pop)
            depth <= depth - 1'b1;
    end

    // Contents need no reset: only entries below depth are ever read meaningfully.
    always_ff @(posedge clk) begin
        if (reset && do_push)
            mem[wr_idx] <= data_in;
    end

endmodule

// File: rtl/pc_call_unit.sv
// pc_call_unit: program counter with hold/inc/jump/call/ret and a return-address stack.
// Ports: clk, reset (sync active-low), en, op, pc_target, err_clr; outputs pc_out, depth,
// stack_full, stack_empty, sticky ovf_err/unf_err.
// Optional macro PC_CALL_UNIT_PREV_PC_EN adds output pc_prev (PC before its last change).
module pc_call_unit
    import pc_call_unit_pkg::*;
#(
    parameter int PC_W        = 12,
    parameter int STEP        = 1,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_PC    = 0,
    localparam int DW         = clog2(STACK_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [OP_W-1:0] op,
    input  logic [PC_W-1:0] pc_target,
    input  logic            err_clr,
    output logic [PC_W-1:0] pc_out,
    output logic [DW-1:0]   depth,
    output logic            stack_full,
    output logic            stack_empty,
    output logic            ovf_err,
    output logic            unf_err
`ifdef PC_CALL_UNIT_PREV_PC_EN
    ,
    output logic [PC_W-1:0] pc_prev
`endif
);

    logic [PC_W-1:0] ret_addr;
    logic [PC_W-1:0] top;
    logic [PC_W-1:0] pc_nxt;
    logic            is_call;
    logic            is_ret;
    logic            push;
    logic            pop;

    assign is_call  = en && op == OP_CALL;
    assign is_ret   = en && op == OP_RET;
    assign push     = is_call && !stack_full;
    assign pop      = is_ret && !stack_empty;
    assign ret_addr = pc_out + PC_W'(STEP);

    // Undefined opcodes and blocked CALL/RET fall through to holding the PC.
    always_comb begin
        pc_nxt = !en                      ? pc_out    :
                 op == OP_INC             ? ret_addr  :
                 (op == OP_JUMP || push)  ? pc_target :
                 pop                      ? top       : pc_out;
    end

    ret_stack #(
        .DATA_W (PC_W),
        .DEPTH  (STACK_DEPTH)
    ) u_stack (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .data_in (ret_addr),
        .top     (top),
        .depth   (depth),
        .full    (stack_full),
        .empty   (stack_empty)
    );

    // A new error event outranks a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_out  <= PC_W'(RESET_PC);
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            pc_out  <= pc_nxt;
            ovf_err <= (is_call && stack_full) || (ovf_err && !err_clr);
            unf_err <= (is_ret && stack_empty) || (unf_err && !err_clr);
        end
    end

`ifdef PC_CALL_UNIT_PREV_PC_EN
    always_ff @(posedge clk) begin
        if (!reset)
            pc_prev <= PC_W'(RESET_PC);
        else if (pc_nxt != pc_out)
            pc_prev <= pc_out;
    end
`endif

endmodule
